// File: rtl/hub75_pkg.sv
// Shared types and defaults for the HUB75 scan controller.
package hub75_pkg;

  // Default panel geometry and colour depth.
  localparam int DEF_COLS     = 32;
  localparam int DEF_ROW_BITS = 3;
  localparam int DEF_PLANES   = 4;
  localparam int DEF_BASE_OE  = 8;

  // rd_data is {r1,g1,b1,r2,g2,b2}; field f sits at [f*PLANES +: PLANES].
  localparam int NUM_FIELDS = 6;
  localparam int F_B2       = 0;
  localparam int F_G2       = 1;
  localparam int F_R2       = 2;
  localparam int F_B1       = 3;
  localparam int F_G1       = 4;
  localparam int F_R1       = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    BLANK   = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } state_t;

  // Index width that stays legal when there is only one item.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down counter timing the lit period of one BCM bit plane.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter  int PLANES  = DEF_PLANES,
  parameter  int BASE_OE = DEF_BASE_OE,
  localparam int PW      = clog2_min1(PLANES),
  localparam int DW      = $clog2(BASE_OE << (PLANES - 1)) + 1
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          load,
  input  logic [PW-1:0] plane,
  output logic          done
);

  logic [DW-1:0] count_reg;
  logic [DW-1:0] count_next;

  // Load the plane weight, otherwise count down and park at zero.
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = DW'(BASE_OE) << plane;
    end else if (count_reg != '0) begin
      count_next = count_reg - DW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!areset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Last lit cycle of the plane.
  assign done = (count_reg == DW'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/8-scan sequencer: shifts a row pair per bit plane from the frame
// buffer, latches it, and lights it for a binary-weighted period.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter  int COLS     = DEF_COLS,
  parameter  int ROW_BITS = DEF_ROW_BITS,
  parameter  int PLANES   = DEF_PLANES,
  parameter  int BASE_OE  = DEF_BASE_OE,
  localparam int CB       = clog2_min1(COLS),
  localparam int AW       = ROW_BITS + CB,
  localparam int PW       = clog2_min1(PLANES),
  localparam int KW       = $clog2(2 * COLS + 1)
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         en,
  output logic [AW-1:0]                rd_addr,
  input  logic [NUM_FIELDS*PLANES-1:0] rd_data,
  output logic                         r1,
  output logic                         g1,
  output logic                         b1,
  output logic                         r2,
  output logic                         g2,
  output logic                         b2,
  output logic [ROW_BITS-1:0]          abc,
  output logic                         oclk,
  output logic                         lat,
  output logic                         oe,
  output logic                         frame_done
);

  localparam logic [KW-1:0]       K_LAST     = KW'(2 * COLS);
  localparam logic [PW-1:0]       LAST_PLANE = PW'(PLANES - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW   = {ROW_BITS{1'b1}};

  state_t              state_reg, state_next;
  logic [ROW_BITS-1:0] row_reg, row_next;
  logic [PW-1:0]       plane_reg, plane_next;
  logic [KW-1:0]       k_reg, k_next;
  logic                timer_load;
  logic                timer_done;
  logic                frame_wrap;

  logic [AW-1:0]         rd_addr_reg, rd_addr_next;
  logic [NUM_FIELDS-1:0] color_reg, color_next;
  logic [ROW_BITS-1:0]   abc_reg, abc_next;
  logic                  oclk_reg, oclk_next;
  logic                  lat_reg, lat_next;
  logic                  oe_reg, oe_next;
  logic                  frame_done_reg, frame_done_next;
  logic [NUM_FIELDS-1:0] plane_bits;

  // Pick the current bit plane out of every colour field of the read word.
  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    logic [PLANES-1:0] field;
    assign field          = rd_data[gi*PLANES +: PLANES];
    assign plane_bits[gi] = field[plane_reg];
  end

  hub75_bcm_timer #(
    .PLANES  (PLANES),
    .BASE_OE (BASE_OE)
  ) u_timer (
    .clk    (clk),
    .areset (areset),
    .load   (timer_load),
    .plane  (plane_reg),
    .done   (timer_done)
  );

  // State and scan-position registers.
  always_ff @(posedge clk) begin
    if (!areset) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      plane_reg <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      plane_reg <= plane_next;
      k_reg     <= k_next;
    end
  end

  // Next state: shift 2*COLS+1 cycles, blank, latch, then light the plane.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    plane_next = plane_reg;
    k_next     = k_reg;
    timer_load = 1'b0;
    frame_wrap = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (en) begin
          state_next = SHIFT;
          row_next   = '0;
          plane_next = '0;
          k_next     = '0;
        end
      end
      SHIFT: begin
        if (k_reg == K_LAST) begin
          state_next = BLANK;
          k_next     = '0;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      BLANK: state_next = LATCH;
      LATCH: begin
        state_next = DISPLAY;
        timer_load = 1'b1;
      end
      DISPLAY: begin
        if (timer_done) begin
          k_next = '0;
          if (plane_reg == LAST_PLANE) begin
            plane_next = '0;
            row_next   = row_reg + ROW_BITS'(1);
            frame_wrap = (row_reg == LAST_ROW);
          end else begin
            plane_next = plane_reg + PW'(1);
          end
          // en is only looked at here, so a started pass always finishes.
          state_next = en ? SHIFT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin values for the next cycle, decoded from the next state so every pin is a flop.
  always_comb begin
    oe_next         = (state_next != DISPLAY);
    lat_next        = (state_next == LATCH);
    oclk_next       = (state_next == SHIFT) && !k_next[0] && (k_next != '0);
    rd_addr_next    = rd_addr_reg;
    color_next      = color_reg;
    abc_next        = abc_reg;
    frame_done_next = frame_wrap;
    if (state_next == SHIFT) begin
      rd_addr_next = {row_next, k_next[CB:1]};
    end
    // Odd shift cycles carry the word addressed on the previous cycle.
    if ((state_reg == SHIFT) && k_reg[0]) begin
      color_next = plane_bits;
    end
    if (state_reg == LATCH) begin
      abc_next = row_reg;
    end
  end

  // Output registers; reset blanks the panel and clears every pin.
  always_ff @(posedge clk) begin
    if (!areset) begin
      rd_addr_reg    <= '0;
      color_reg      <= '0;
      abc_reg        <= '0;
      oclk_reg       <= 1'b0;
      lat_reg        <= 1'b0;
      oe_reg         <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      rd_addr_reg    <= rd_addr_next;
      color_reg      <= color_next;
      abc_reg        <= abc_next;
      oclk_reg       <= oclk_next;
      lat_reg        <= lat_next;
      oe_reg         <= oe_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign rd_addr    = rd_addr_reg;
  assign r1         = color_reg[F_R1];
  assign g1         = color_reg[F_G1];
  assign b1         = color_reg[F_B1];
  assign r2         = color_reg[F_R2];
  assign g2         = color_reg[F_G2];
  assign b2         = color_reg[F_B2];
  assign abc        = abc_reg;
  assign oclk       = oclk_reg;
  assign lat        = lat_reg;
  assign oe         = oe_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl: pass-level reference model built
// from the pass/row/frame timing rules, with a synchronous frame-buffer model.
module tb_hub75_scan_ctrl;

  localparam int COLS     = 32;
  localparam int ROW_BITS = 3;
  localparam int PLANES   = 4;
  localparam int BASE_OE  = 8;
  localparam int AW       = ROW_BITS + $clog2(COLS);
  localparam int DWID     = 6 * PLANES;
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int FRAME    = ROWS * (PLANES * (2 * COLS + 3) + BASE_OE * ((1 << PLANES) - 1));
  localparam logic [DWID-1:0] R1_0101 = DWID'(4'b0101) << (5 * PLANES);

  logic            clk = 1'b0;
  logic            areset = 1'b0;
  logic            en = 1'b0;
  logic [AW-1:0]   rd_addr;
  logic [DWID-1:0] rd_data = '0;
  logic            r1, g1, b1, r2, g2, b2;
  logic [ROW_BITS-1:0] abc;
  logic            oclk, lat, oe, frame_done;

  logic [DWID-1:0] mem [0:ROWS*COLS-1];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_fd     = -1;
  int prev_abc    = 0;
  bit fd_pending  = 1'b0;

  hub75_scan_ctrl #(
    .COLS     (COLS),
    .ROW_BITS (ROW_BITS),
    .PLANES   (PLANES),
    .BASE_OE  (BASE_OE)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .en         (en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .r1         (r1),
    .g1         (g1),
    .b1         (b1),
    .r2         (r2),
    .g2         (g2),
    .b2         (b2),
    .abc        (abc),
    .oclk       (oclk),
    .lat        (lat),
    .oe         (oe),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Frame buffer: one-cycle synchronous read.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected {r1,g1,b1,r2,g2,b2} for a column: bit 'plane' of each field.
  function automatic int exp_colour(input int row, input int c, input int plane);
    logic [DWID-1:0] w;
    int v;
    w = mem[row * COLS + c];
    v = 0;
    for (int f = 0; f < 6; f++) v = v | (int'(w[f * PLANES + plane]) << f);
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (frame_done === 1'b1) begin
      if (last_fd >= 0) chk("fd_period", 32'(cyc - last_fd), FRAME);
      last_fd = cyc;
    end
  endtask

  task automatic chk_quiet(input string tag, input int exp_abc);
    chk({tag, "_oe"}, 32'(oe), 1);
    chk({tag, "_lat"}, 32'(lat), 0);
    chk({tag, "_oclk"}, 32'(oclk), 0);
    chk({tag, "_abc"}, 32'(abc), exp_abc);
  endtask

  // One pass from the first SHIFT cycle. drop_k: SHIFT cycle after which en
  // is dropped; rst_d: display cycle after which reset is asserted (-1 = none).
  task automatic run_pass(input int row, input int plane, input int drop_k, input int rst_d);
    int rises;
    logic prev_oclk;
    int len;
    rises     = 0;
    prev_oclk = 1'b0;
    len       = BASE_OE << plane;
    for (int k = 0; k <= 2 * COLS; k++) begin
      tick();
      chk("shift_oe", 32'(oe), 1);
      chk("shift_lat", 32'(lat), 0);
      chk("shift_abc", 32'(abc), prev_abc);
      chk("shift_fd", 32'(frame_done), int'(k == 0 && fd_pending));
      chk("shift_oclk", 32'(oclk), int'(k >= 2 && (k % 2) == 0));
      if ((k % 2) == 0 && k < 2 * COLS) chk("rd_addr", 32'(rd_addr), row * COLS + k / 2);
      if (oclk === 1'b1 && prev_oclk !== 1'b1) begin
        if (rises < COLS) chk("colour", 32'({r1, g1, b1, r2, g2, b2}), exp_colour(row, rises, plane));
        rises++;
      end
      prev_oclk = oclk;
      if (k == 0) fd_pending = 1'b0;
      if (k == drop_k) en = 1'b0;
    end
    chk("oclk_rises", 32'(rises), COLS);
    tick();
    chk_quiet("blank", prev_abc);
    tick();
    chk("latch_lat", 32'(lat), 1);
    chk("latch_oe", 32'(oe), 1);
    chk("latch_abc", 32'(abc), prev_abc);
    for (int d = 0; d < len; d++) begin
      tick();
      chk("disp_oe", 32'(oe), 0);
      chk("disp_lat", 32'(lat), 0);
      chk("disp_oclk", 32'(oclk), 0);
      chk("disp_abc", 32'(abc), row);
      chk("disp_fd", 32'(frame_done), 0);
      if (d == rst_d) begin
        areset = 1'b0;
        tick();
        chk_quiet("rst", 0);
        chk("rst_colour", 32'({r1, g1, b1, r2, g2, b2}), 0);
        chk("rst_fd", 32'(frame_done), 0);
        prev_abc   = 0;
        fd_pending = 1'b0;
        return;
      end
    end
    prev_abc = row;
    if (row == ROWS - 1 && plane == PLANES - 1) fd_pending = 1'b1;
  endtask

  initial begin
    // Row 0 holds the directed r1=0101 pattern, the rest is random.
    for (int i = 0; i < ROWS * COLS; i++) mem[i] = (i < COLS) ? R1_0101 : DWID'($urandom);

    // Reset held for three cycles with en already high.
    areset = 1'b0;
    en     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("reset", 0);
      chk("reset_colour", 32'({r1, g1, b1, r2, g2, b2}), 0);
      chk("reset_fd", 32'(frame_done), 0);
    end
    areset = 1'b1;

    // Two full frames; the second frame_done pulse checks the frame period.
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < ROWS; r++)
        for (int p = 0; p < PLANES; p++) run_pass(r, p, -1, -1);

    // Drop en mid-SHIFT of row 2, plane 1: pass completes, then idle.
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < PLANES; p++) run_pass(r, p, -1, -1);
    run_pass(2, 0, -1, -1);
    run_pass(2, 1, 10, -1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_quiet("idle", 2);
      chk("idle_fd", 32'(frame_done), 0);
    end

    // Re-enable restarts at row 0, plane 0; then reset during a 64-cycle display.
    en = 1'b1;
    for (int p = 0; p < PLANES; p++) run_pass(0, p, -1, -1);
    for (int p = 0; p < PLANES - 1; p++) run_pass(1, p, -1, -1);
    run_pass(1, PLANES - 1, -1, 20);
    tick();
    chk_quiet("rst_hold", 0);
    areset = 1'b1;
    run_pass(0, 0, -1, -1);
    run_pass(0, 1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
